// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: frame sequencer for the serial 8-point FFT datapath.
// It loads 8 real samples, feeds them to the datapath, drives the stage
// twiddles, waits out the datapath latency, then streams the 8 results
// tagged with their bin index.
// Optional feature: define FFT8_FRAME_CTRL_BITREV_EN to buffer the results
// and emit them in natural bin order through an extra REORDER phase.
//
// Handshake: a sample moves on every rising edge where in_valid and in_ready
// are both high. in_ready depends only on the state and on clear. The
// source must hold in_data stable until it is accepted. The output stream
// has no backpressure.
module fft8_frame_ctrl #(
  parameter int W       = 8,
  parameter int OUT_LAT = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  output logic                fft_clear,
  output logic signed [W-1:0] fft_a_r,
  output logic signed [W-1:0] fft_a_im,
  output logic signed [W-1:0] fft_c_r,
  output logic signed [W-1:0] fft_c_im,
  output logic signed [W-1:0] fft_d_r,
  output logic signed [W-1:0] fft_d_im,
  input  logic signed [W-1:0] fft_y_r,
  input  logic signed [W-1:0] fft_y_im,
  output logic                out_valid,
  output logic signed [W-1:0] out_y_r,
  output logic signed [W-1:0] out_y_im,
  output logic [2:0]          out_index,
  output logic                frame_done,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_LOAD, S_FEED, S_TWID, S_WAIT, S_DRAIN, S_REORDER
  } state_t;

  localparam logic signed [W-1:0] P1 = W'(1);
  localparam logic signed [W-1:0] M1 = '1;
  localparam logic signed [W-1:0] Z0 = '0;
  localparam logic [3:0] WAIT_LAST = 4'(OUT_LAT - 1);

  state_t              state, nxt_state;
  logic [3:0]          cnt, nxt_cnt;
  logic                accept;
  logic signed [W-1:0] sbuf [8];
  logic signed [W-1:0] tw_c_r, tw_c_im, tw_d_r, tw_d_im;

`ifdef FFT8_FRAME_CTRL_BITREV_EN
  logic signed [W-1:0] ybuf_r  [8];
  logic signed [W-1:0] ybuf_im [8];

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction
`endif

  assign in_ready = (state == S_LOAD) && !clear;
  assign accept   = in_valid && in_ready;
  // The real-input datapath never gets an imaginary sample.
  assign fft_a_im = Z0;

  // Next state and phase counter; the counter restarts on every state entry.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 4'd1;
    case (state)
      S_LOAD: begin
        nxt_cnt = accept ? cnt + 4'd1 : cnt;
        if (accept && cnt == 4'd7) begin
          nxt_state = S_FEED;
          nxt_cnt   = 4'd0;
        end
      end
      S_FEED:  if (cnt == 4'd7)     begin nxt_state = S_TWID;  nxt_cnt = 4'd0; end
      S_TWID:  if (cnt == 4'd5)     begin nxt_state = S_WAIT;  nxt_cnt = 4'd0; end
      S_WAIT:  if (cnt == WAIT_LAST) begin nxt_state = S_DRAIN; nxt_cnt = 4'd0; end
`ifdef FFT8_FRAME_CTRL_BITREV_EN
      S_DRAIN:   if (cnt == 4'd7) begin nxt_state = S_REORDER; nxt_cnt = 4'd0; end
      S_REORDER: if (cnt == 4'd7) begin nxt_state = S_LOAD;    nxt_cnt = 4'd0; end
`else
      S_DRAIN:   if (cnt == 4'd7) begin nxt_state = S_LOAD;    nxt_cnt = 4'd0; end
`endif
      default: begin
        nxt_state = S_LOAD;
        nxt_cnt   = 4'd0;
      end
    endcase
    if (clear) begin
      nxt_state = S_LOAD;
      nxt_cnt   = 4'd0;
    end
  end

  // Twiddle table for the cycle about to start, so the outputs can be registered.
  always_comb begin
    tw_c_r = Z0; tw_c_im = Z0; tw_d_r = Z0; tw_d_im = Z0;
    if (nxt_state == S_TWID) begin
      case (nxt_cnt)
        4'd0: begin tw_c_r = P1; tw_c_im = Z0; tw_d_r = P1; tw_d_im = Z0; end
        4'd1: begin tw_c_r = P1; tw_c_im = M1; tw_d_r = Z0; tw_d_im = M1; end
        4'd2: begin tw_c_r = Z0; tw_c_im = M1; end
        4'd3: begin tw_c_r = M1; tw_c_im = M1; end
        4'd4: begin tw_d_r = P1; tw_d_im = Z0; end
        4'd5: begin tw_d_r = Z0; tw_d_im = M1; end
        default: ;
      endcase
    end
  end

  // FSM, sample/result buffers and all registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= S_LOAD;
      cnt        <= 4'd0;
      for (int i = 0; i < 8; i++) sbuf[i] <= Z0;
`ifdef FFT8_FRAME_CTRL_BITREV_EN
      for (int i = 0; i < 8; i++) begin
        ybuf_r[i]  <= Z0;
        ybuf_im[i] <= Z0;
      end
`endif
      fft_clear  <= 1'b1;
      fft_a_r    <= Z0;
      fft_c_r    <= Z0;
      fft_c_im   <= Z0;
      fft_d_r    <= Z0;
      fft_d_im   <= Z0;
      out_valid  <= 1'b0;
      out_y_r    <= Z0;
      out_y_im   <= Z0;
      out_index  <= 3'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (accept) sbuf[cnt[2:0]] <= in_data;
      fft_clear  <= (nxt_state == S_FEED) && (nxt_cnt == 4'd0);
      fft_a_r    <= (nxt_state == S_FEED) ? sbuf[nxt_cnt[2:0]] : Z0;
      fft_c_r    <= tw_c_r;
      fft_c_im   <= tw_c_im;
      fft_d_r    <= tw_d_r;
      fft_d_im   <= tw_d_im;
      busy       <= (nxt_state != S_LOAD);
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
`ifdef FFT8_FRAME_CTRL_BITREV_EN
      if (state == S_DRAIN) begin
        ybuf_r[cnt[2:0]]  <= fft_y_r;
        ybuf_im[cnt[2:0]] <= fft_y_im;
      end
      if (state == S_REORDER) begin
        out_valid  <= 1'b1;
        out_y_r    <= ybuf_r[bitrev3(cnt[2:0])];
        out_y_im   <= ybuf_im[bitrev3(cnt[2:0])];
        out_index  <= cnt[2:0];
        frame_done <= (cnt == 4'd7);
      end
`else
      if (state == S_DRAIN) begin
        out_valid  <= 1'b1;
        out_y_r    <= fft_y_r;
        out_y_im   <= fft_y_im;
        out_index  <= cnt[2:0];
        frame_done <= (cnt == 4'd7);
      end
`endif
    end
  end

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: randomized and directed bench for fft8_frame_ctrl,
// checked every cycle against a frame-schedule model of the controller.
module tb_fft8_frame_ctrl;
  localparam int W = 8;
  localparam int L = 4;
`ifdef FFT8_FRAME_CTRL_BITREV_EN
  localparam int RUN_LEN = 30 + L;
`else
  localparam int RUN_LEN = 22 + L;
`endif

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] in_data = '0;
  logic fft_clear;
  logic signed [W-1:0] fft_a_r, fft_a_im, fft_c_r, fft_c_im, fft_d_r, fft_d_im;
  logic signed [W-1:0] fy_r = '0, fy_im = '0;
  logic out_valid, frame_done, busy;
  logic signed [W-1:0] out_y_r, out_y_im;
  logic [2:0] out_index;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fft8_frame_ctrl #(.W(W), .OUT_LAT(L)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fft_clear(fft_clear),
    .fft_a_r(fft_a_r), .fft_a_im(fft_a_im), .fft_c_r(fft_c_r), .fft_c_im(fft_c_im),
    .fft_d_r(fft_d_r), .fft_d_im(fft_d_im), .fft_y_r(fy_r), .fft_y_im(fy_im),
    .out_valid(out_valid), .out_y_r(out_y_r), .out_y_im(out_y_im),
    .out_index(out_index), .frame_done(frame_done), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitrev3(input int j);
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
  endfunction

  // ---------------- reference model ----------------
  // m_load: waiting for samples; otherwise m_r counts cycles since F0.
  bit m_load = 1, m_valid = 0, m_done = 0, m_fclr = 1, m_rst = 1;
  int m_cnt = 0, m_r = 0, m_oy_r = 0, m_oy_im = 0, m_oidx = 0;
  int m_smp[8];
  int m_yb_r[8];
  int m_yb_im[8];
  int c_tab_r[6]  = '{1, 1, 0, -1, 0, 0};
  int c_tab_im[6] = '{0, -1, -1, -1, 0, 0};
  int d_tab_r[6]  = '{1, 0, 0, 0, 1, 0};
  int d_tab_im[6] = '{0, -1, 0, 0, 0, -1};

  // Capture logs used for literal checks of directed frames.
  bit ydir = 0, log_en = 0;
  int feed_q[$], fclr_q[$], oyr_q[$], oyi_q[$], oidx_q[$], done_q[$];
  int t3[4], t5[4];
  int rdy_at_last = -1, valid_cnt = 0;

  // ---------------- scoreboard: compare then advance model ----------------
  always @(negedge clk) begin
    int e_ar, e_cr, e_ci, e_dr, e_di, d, j;
    bit feed;
    feed = !m_load && m_r < 8;
    e_ar = feed ? m_smp[m_r] : 0;
    e_cr = 0; e_ci = 0; e_dr = 0; e_di = 0;
    if (!m_load && m_r >= 8 && m_r < 14) begin
      e_cr = c_tab_r[m_r-8]; e_ci = c_tab_im[m_r-8];
      e_dr = d_tab_r[m_r-8]; e_di = d_tab_im[m_r-8];
    end
    check("in_ready", int'(in_ready), int'(m_load && !clear));
    check("busy", int'(busy), int'(!m_load));
    check("fft_clear", int'(fft_clear), int'(m_fclr));
    check("fft_a_r", int'(fft_a_r), e_ar);
    check("fft_a_im", int'(fft_a_im), 0);
    check("fft_c_r", int'(fft_c_r), e_cr);
    check("fft_c_im", int'(fft_c_im), e_ci);
    check("fft_d_r", int'(fft_d_r), e_dr);
    check("fft_d_im", int'(fft_d_im), e_di);
    check("out_valid", int'(out_valid), int'(m_valid));
    check("frame_done", int'(frame_done), int'(m_done));
    if (m_valid || m_rst) begin
      check("out_y_r", int'(out_y_r), m_oy_r);
      check("out_y_im", int'(out_y_im), m_oy_im);
      check("out_index", int'(out_index), m_oidx);
    end
    if (log_en) begin
      if (feed) begin
        feed_q.push_back(int'(fft_a_r));
        fclr_q.push_back(int'(fft_clear));
      end
      if (!m_load && m_r == 11) begin
        t3[0] = int'(fft_c_r); t3[1] = int'(fft_c_im); t3[2] = int'(fft_d_r); t3[3] = int'(fft_d_im);
      end
      if (!m_load && m_r == 13) begin
        t5[0] = int'(fft_c_r); t5[1] = int'(fft_c_im); t5[2] = int'(fft_d_r); t5[3] = int'(fft_d_im);
      end
      if (out_valid) begin
        oyr_q.push_back(int'(out_y_r));
        oyi_q.push_back(int'(out_y_im));
        oidx_q.push_back(int'(out_index));
        done_q.push_back(int'(frame_done));
        if (out_index == 3'd7) rdy_at_last = int'(in_ready);
        valid_cnt++;
      end
    end
    // advance the model by one clock using this cycle's inputs
    if (clear) begin
      m_load = 1; m_cnt = 0; m_r = 0;
      foreach (m_smp[i]) begin m_smp[i] = 0; m_yb_r[i] = 0; m_yb_im[i] = 0; end
      m_valid = 0; m_done = 0; m_oy_r = 0; m_oy_im = 0; m_oidx = 0;
      m_fclr = 1; m_rst = 1;
    end else begin
      m_rst = 0; m_valid = 0; m_done = 0;
      if (!m_load) begin
        d = m_r - (14 + L);
`ifdef FFT8_FRAME_CTRL_BITREV_EN
        if (d >= 0 && d < 8) begin m_yb_r[d] = int'(fy_r); m_yb_im[d] = int'(fy_im); end
        if (d >= 8 && d < 16) begin
          j = d - 8;
          m_valid = 1; m_oy_r = m_yb_r[bitrev3(j)]; m_oy_im = m_yb_im[bitrev3(j)];
          m_oidx = j; m_done = (j == 7);
        end
`else
        if (d >= 0 && d < 8) begin
          m_valid = 1; m_oy_r = int'(fy_r); m_oy_im = int'(fy_im);
          m_oidx = d; m_done = (d == 7);
        end
`endif
        m_r++;
        if (m_r == RUN_LEN) begin m_load = 1; m_cnt = 0; end
      end else if (in_valid) begin
        m_smp[m_cnt] = int'(in_data);
        m_cnt++;
        if (m_cnt == 8) begin m_load = 0; m_r = 0; end
      end
      m_fclr = !m_load && m_r == 0;
    end
  end

  // ---------------- datapath result driver ----------------
  // Directed mode returns 10+k / -k in drain cycle Dk; otherwise random.
  always @(posedge clk) begin
    #1;
    if (ydir && !m_load && m_r >= 14 + L && m_r < 22 + L) begin
      fy_r  = W'(10 + (m_r - 14 - L));
      fy_im = W'(-(m_r - 14 - L));
    end else begin
      fy_r  = W'($urandom_range(0, 255));
      fy_im = W'($urandom_range(0, 255));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int v, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) step();
    in_data = W'(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL accept_wait: in_ready low for %0d cycles, expected high within 200", n);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_load && !m_valid) && n < 300) begin step(); n++; end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL idle_wait: frame not finished after %0d cycles, expected <300", n);
    end
    repeat (2) step();
  endtask

  task automatic clear_logs();
    feed_q.delete(); fclr_q.delete(); oyr_q.delete(); oyi_q.delete();
    oidx_q.delete(); done_q.delete();
    rdy_at_last = -1; valid_cnt = 0;
    foreach (t3[i]) begin t3[i] = 99; t5[i] = 99; end
  endtask

  int smp_a[8] = '{4, 1, 2, -3, 1, -2, 0, 3};
`ifdef FFT8_FRAME_CTRL_BITREV_EN
  int exp_y[8] = '{10, 14, 12, 16, 11, 15, 13, 17};
`else
  int exp_y[8] = '{10, 11, 12, 13, 14, 15, 16, 17};
`endif

  // Literal expectations for a directed frame loaded with smp_a.
  task automatic check_frame();
    check("feed_len", feed_q.size(), 8);
    for (int i = 0; i < 8 && i < feed_q.size(); i++) begin
      check("feed_a_r", feed_q[i], smp_a[i]);
      check("feed_fclr", fclr_q[i], (i == 0) ? 1 : 0);
    end
    check("t3_c_r", t3[0], -1); check("t3_c_im", t3[1], -1);
    check("t3_d_r", t3[2], 0);  check("t3_d_im", t3[3], 0);
    check("t5_c_r", t5[0], 0);  check("t5_c_im", t5[1], 0);
    check("t5_d_r", t5[2], 0);  check("t5_d_im", t5[3], -1);
    check("out_len", oyr_q.size(), 8);
    for (int j = 0; j < 8 && j < oyr_q.size(); j++) begin
      check("lit_y_r", oyr_q[j], exp_y[j]);
      check("lit_y_im", oyi_q[j], -(exp_y[j] - 10));
      check("lit_index", oidx_q[j], j);
      check("lit_done", done_q[j], (j == 7) ? 1 : 0);
    end
    check("ready_at_last", rdy_at_last, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_fft_clear", int'(fft_clear), 1);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);

    // directed frame, consecutive samples
    step();
    clear_logs(); log_en = 1; ydir = 1;
    for (int i = 0; i < 8; i++) send_sample(smp_a[i], 0);
    wait_idle();
    check_frame();

    // same frame with in_valid low on alternate cycles
    clear_logs();
    for (int i = 0; i < 8; i++) send_sample(smp_a[i], 1);
    wait_idle();
    check_frame();

    // abort in TWID T2, then a fresh frame
    clear_logs();
    for (int i = 0; i < 8; i++) send_sample($urandom_range(0, 255) - 128, 0);
    n = 0;
    while (!(!m_load && m_r == 10) && n < 100) begin step(); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL reach_t2: waited %0d cycles, expected <100", n);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_c_r", int'(fft_c_r), 0);
    check("abort_c_im", int'(fft_c_im), 0);
    check("abort_d_r", int'(fft_d_r), 0);
    check("abort_d_im", int'(fft_d_im), 0);
    check("abort_in_ready", int'(in_ready), 1);
    repeat (30) step();
    check("abort_no_valid", valid_cnt, 0);
    clear_logs();
    for (int i = 0; i < 8; i++) send_sample(smp_a[i], 0);
    wait_idle();
    check_frame();

    // random frames, random gaps, one mid-load clear
    log_en = 0; ydir = 0;
    for (int f = 0; f < 12; f++) begin
      for (int s = 0; s < 8; s++) begin
        if (f == 5 && s == 3) begin
          clear = 1'b1;
          step();
          clear = 1'b0;
        end
        send_sample($urandom_range(0, 255) - 128, $urandom_range(0, 2));
      end
      if (f == 5) for (int s = 0; s < 3; s++) send_sample($urandom_range(0, 255) - 128, 0);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound.
  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Frame sequencer for the serial 8-point FFT datapath (fft_8point).
- Buffers 8 real input samples via a valid/ready handshake, then streams them into the datapath's a_r/a_im inputs.
- Generates the stage twiddle sequences on c_r/c_im and d_r/d_im, waits for the datapath latency, and captures the 8 complex results as a tagged output stream.
- Sits between the sample source and fft_8point; it is the only driver of fft_8point's inputs.

Parameters:
- W, 8, sample/twiddle/result width; all values are two's-complement signed.
- OUT_LAT, 4, cycles from the end of TWID to the first valid fft_y sample (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous reset, active-high.
- in_valid  in  1  source has a sample on in_data.
- in_ready  out  1  controller accepts a sample this cycle.
- in_data  in  W  real input sample.
- fft_clear  out  1  clear to the datapath.
- fft_a_r, fft_a_im  out  W each  sample to the datapath.
- fft_c_r, fft_c_im  out  W each  twiddle, stage 2.
- fft_d_r, fft_d_im  out  W each  twiddle, stage 3.
- fft_y_r, fft_y_im  in  W each  datapath result.
- out_valid  out  1  out_y_r/out_y_im/out_index are valid.
- out_y_r, out_y_im  out  W each  captured result.
- out_index  out  3  bin index of the current result.
- frame_done  out  1  one-cycle pulse with the last result of a frame.
- busy  out  1  high in every state except LOAD.

Behaviour:
- States and transitions:
  - LOAD → FEED (8 cycles) → TWID (6 cycles) → WAIT (OUT_LAT cycles) → DRAIN (8 cycles) → LOAD.
  - A single 4-bit counter is reset on every state entry.
- Reset: while clear=1 and in the cycle after it:
  - state=LOAD, counter=0, sample buffer=0.
  - All fft_* data outputs=0, fft_clear=1.
  - out_valid=0, out_y_*=0, out_index=0, frame_done=0, busy=0, in_ready=0.
  - in_ready rises the first cycle clear is low.
  - clear mid-frame aborts from any state; partially loaded samples are discarded.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready writes in_data to buf[cnt] and increments cnt.
  - Gaps in in_valid are allowed.
  - On the 8th acceptance, go to FEED the next cycle; in_ready=0 from then.
- FEED, cycles F0..F7:
  - fft_a_r=buf[k], fft_a_im=0.
  - fft_clear=1 in F0 only.
- TWID, cycles T0..T5:
  - fft_a_r/a_im=0.
  - c (r,im): T0 (1,0), T1 (1,-1), T2 (0,-1), T3 (-1,-1), T4 and T5 (0,0).
  - d (r,im): T0 (1,0), T1 (0,-1), T2 and T3 (0,0), T4 (1,0), T5 (0,-1).
  - Outside TWID all c/d outputs=0; X is never driven.
- WAIT: all fft_* data outputs=0 for OUT_LAT cycles.
- DRAIN, cycles D0..D7:
  - In Dk, fft_y_r/fft_y_im are registered into out_y_*.
  - out_index=k; out_valid=1 in the cycle after Dk, so valid spans 8 consecutive cycles.
  - frame_done=1 with out_index=7.
  - The output has no backpressure; the consumer must accept every valid cycle.
- Back-to-back frames: LOAD is re-entered the cycle after D7, so in_ready=1 coincides with the final out_valid.
- Minimum frame period: 8 + 8 + 6 + OUT_LAT + 8 cycles.
- Ignored input: in_valid is ignored when in_ready=0; no sample is lost, the source simply holds.
- busy=1 from F0 until the cycle after D7.

Optional Feature:
- Macro: FFT8_FRAME_CTRL_BITREV_EN.
- Defined:
  - DRAIN stores fft_y into an 8-entry result buffer and asserts no out_valid.
  - A REORDER state follows (8 cycles).
  - In cycle Rj it emits buf_y[bitrev3(j)] with out_index=j, so results are in natural bin order.
  - frame_done is asserted with j=7; minimum frame period grows by 8.
- Undefined: behaviour is as above, results in datapath order, no REORDER state.

Test Plan:
- Reset: clear=1 for 3 cycles, then 0 → all outputs 0 and fft_clear=1 during clear; in_ready=1 on the first cycle after release.
- Load/feed: in_data 4,1,2,-3,1,-2,0,3 on consecutive cycles → F0..F7 show fft_a_r=4,1,2,-3,1,-2,0,3 with fft_a_im=0; fft_clear=1 in F0 only.
- Gapped input: the same 8 samples with in_valid low on alternate cycles → identical FEED sequence; FEED begins exactly 1 cycle after the 8th acceptance.
- Twiddles: check T0..T5 c/d values exactly as listed (e.g. T3 c=(-1,-1), d=(0,0); T5 d=(0,-1)) and all c/d=0 in every other state.
- Drain (OUT_LAT=4): model fft_y_r=10+k, fft_y_im=-k in Dk → out_valid for 8 cycles with out_y_r=10..17, out_index=0..7, frame_done only with index 7; in_ready=1 in that same cycle.
- Abort: assert clear in TWID T2 → next cycle state=LOAD, c/d=0, busy=0, and no out_valid. Then a fresh 8-sample frame completes normally. With FFT8_FRAME_CTRL_BITREV_EN, out_index j carries the Dk result with k=bitrev3(j), e.g. out_index=1 shows out_y_r=14.
